// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the segmented core.
// Covers writeback source encodings, load funct3 codes and the default datapath width.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Selects a byte, half or word from an aligned memory word, then sign- or zero-extends it.
// Also flags accesses that are not naturally aligned. Purely combinational.
module load_extract
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = off[0];
            end
            // lw and every unlisted code return the full word.
            default: begin
                data       = word;
                misaligned = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback source select for the RV32I core.
// All register-file outputs are flops, so they stay stable across the negedge commit.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_ruwr,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_src,
    input  logic [2:0]       mem_dm_ctrl,
    input  logic [XLEN-1:0]  mem_alu_res,
    input  logic [XLEN-1:0]  mem_rd_word,
    input  logic [XLEN-1:0]  mem_pc4,
    output logic [XLEN-1:0]  RuDataWrite,
    output logic [4:0]       rd,
    output logic             Ruwr,
    output logic             wb_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired
);

    logic [XLEN-1:0] load_data;
    logic            load_misaligned;
    logic [XLEN-1:0] sel_data;
    logic            misaligned;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .word       (mem_rd_word),
        .off        (mem_alu_res[1:0]),
        .funct3     (mem_dm_ctrl),
        .data       (load_data),
        .misaligned (load_misaligned)
    );

    // The reserved source code 11 falls through to the ALU result.
    always_comb begin
        sel_data   = mem_alu_res;
        misaligned = 1'b0;
        case (mem_wb_src)
            WB_MEM: begin
                sel_data   = load_data;
                misaligned = load_misaligned;
            end
            WB_PC4:  sel_data = mem_pc4;
            default: sel_data = mem_alu_res;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            RuDataWrite  <= '0;
            rd           <= '0;
            Ruwr         <= 1'b0;
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            retired      <= '0;
        end else if (flush) begin
            RuDataWrite  <= '0;
            rd           <= '0;
            Ruwr         <= 1'b0;
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else if (!stall) begin
            RuDataWrite  <= mem_valid ? sel_data : '0;
            rd           <= mem_valid ? mem_rd : '0;
            Ruwr         <= mem_valid & mem_ruwr & (mem_rd != 5'd0) & ~misaligned;
            wb_valid     <= mem_valid;
            misalign_err <= mem_valid & misaligned;
            // Counts every captured instruction, including suppressed writes.
            if (mem_valid) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected outputs are queued as stimulus is driven.
// Each queued expectation is compared against the outputs sampled after the matching posedge.
module tb_writeback_stage;
    import riscv_pkg::*;

    localparam int XL = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [31:0]   data;
        logic [4:0]    rd;
        logic          ruwr;
        logic          valid;
        logic          mis;
        logic [CW-1:0] retired;
    } out_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic        ruwr;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] word;
        logic [31:0] pc4;
    } in_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ruwr = 1'b0;
    logic [4:0]    mem_rd = '0;
    logic [1:0]    mem_wb_src = '0;
    logic [2:0]    mem_dm_ctrl = '0;
    logic [XL-1:0] mem_alu_res = '0;
    logic [XL-1:0] mem_rd_word = '0;
    logic [XL-1:0] mem_pc4 = '0;
    logic [XL-1:0] RuDataWrite;
    logic [4:0]    rd;
    logic          Ruwr;
    logic          wb_valid;
    logic          misalign_err;
    logic [CW-1:0] retired;

    int   checks = 0;
    int   errors = 0;
    out_t cur = '0;
    out_t sb_exp[$];
    out_t sb_obs[$];

    writeback_stage #(.XLEN(XL), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_ruwr     (mem_ruwr),
        .mem_rd       (mem_rd),
        .mem_wb_src   (mem_wb_src),
        .mem_dm_ctrl  (mem_dm_ctrl),
        .mem_alu_res  (mem_alu_res),
        .mem_rd_word  (mem_rd_word),
        .mem_pc4      (mem_pc4),
        .RuDataWrite  (RuDataWrite),
        .rd           (rd),
        .Ruwr         (Ruwr),
        .wb_valid     (wb_valid),
        .misalign_err (misalign_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic v, input logic w, input logic [4:0] d,
                               input logic [1:0] s, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] m,
                               input logic [31:0] p);
        in_t t;
        t = '{stall: 1'b0, flush: 1'b0, valid: v, ruwr: w, rd: d, src: s, f3: f,
              alu: a, word: m, pc4: p};
        return t;
    endfunction

    function automatic out_t model(input out_t prev, input logic r, input in_t s);
        out_t        n;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ld;
        logic        mis;
        n = prev;
        if (r) begin
            n = '0;
        end else if (s.flush) begin
            n.data  = '0;
            n.rd    = '0;
            n.ruwr  = 1'b0;
            n.valid = 1'b0;
            n.mis   = 1'b0;
        end else if (!s.stall) begin
            case (s.alu[1:0])
                2'd0:    b = s.word[7:0];
                2'd1:    b = s.word[15:8];
                2'd2:    b = s.word[23:16];
                default: b = s.word[31:24];
            endcase
            h   = s.alu[1] ? s.word[31:16] : s.word[15:0];
            mis = 1'b0;
            case (s.f3)
                3'b000:  ld = {{24{b[7]}}, b};
                3'b100:  ld = {24'h0, b};
                3'b001: begin ld = {{16{h[15]}}, h}; mis = s.alu[0]; end
                3'b101: begin ld = {16'h0, h}; mis = s.alu[0]; end
                default: begin ld = s.word; mis = (s.alu[1:0] != 2'd0); end
            endcase
            if (s.src != 2'b01) mis = 1'b0;
            if (!s.valid)            n.data = '0;
            else if (s.src == 2'b01) n.data = ld;
            else if (s.src == 2'b10) n.data = s.pc4;
            else                     n.data = s.alu;
            n.rd      = s.valid ? s.rd : 5'd0;
            n.ruwr    = s.valid && s.ruwr && (s.rd != 5'd0) && !mis;
            n.valid   = s.valid;
            n.mis     = s.valid && mis;
            n.retired = prev.retired + (s.valid ? CW'(1) : CW'(0));
        end
        return n;
    endfunction

    // Drives one cycle of stimulus, queues its expectation and records what the DUT produced.
    task automatic step(input logic r, input in_t s);
        out_t o;
        rst         = r;
        stall       = s.stall;
        flush       = s.flush;
        mem_valid   = s.valid;
        mem_ruwr    = s.ruwr;
        mem_rd      = s.rd;
        mem_wb_src  = s.src;
        mem_dm_ctrl = s.f3;
        mem_alu_res = s.alu;
        mem_rd_word = s.word;
        mem_pc4     = s.pc4;
        cur = model(cur, r, s);
        sb_exp.push_back(cur);
        @(posedge clk);
        #1;
        o = '{data: RuDataWrite, rd: rd, ruwr: Ruwr, valid: wb_valid, mis: misalign_err,
              retired: retired};
        sb_obs.push_back(o);
    endtask

    task automatic test_reset();
        out_t e, o;
        step(1'b1, mk(1'b1, 1'b1, 5'd9, 2'b00, F3_LW, 32'hDEAD_BEEF, '0, '0));
        step(1'b1, mk(1'b0, 1'b0, 5'd0, 2'b00, F3_LW, '0, '0, '0));
        checks++;
        if ({RuDataWrite, rd, Ruwr, wb_valid, misalign_err, retired} !== '0) begin
            errors++;
            $display("FAIL reset_zero got data=%h rd=%0d ruwr=%b v=%b mis=%b ret=%0d",
                     RuDataWrite, rd, Ruwr, wb_valid, misalign_err, retired);
        end
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset got %h exp %h", o, e); end
        end
    endtask

    task automatic test_alu();
        out_t e, o;
        step(1'b0, mk(1'b1, 1'b1, 5'd5, 2'b00, F3_LW, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4));
        checks++;
        if (RuDataWrite !== 32'h1234_5678 || rd !== 5'd5 || Ruwr !== 1'b1 || retired !== 4'd1) begin
            errors++;
            $display("FAIL alu_write got data=%h rd=%0d ruwr=%b ret=%0d exp 12345678/5/1/1",
                     RuDataWrite, rd, Ruwr, retired);
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd7, 2'b11, F3_LW, 32'hCAFE_0003, 32'h0, 32'h8));
        step(1'b0, mk(1'b0, 1'b1, 5'd7, 2'b00, F3_LW, 32'h5555_5555, 32'h0, 32'h8));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL alu got %h exp %h", o, e); end
        end
    endtask

    task automatic test_loads();
        out_t e, o;
        step(1'b0, mk(1'b1, 1'b1, 5'd10, 2'b01, F3_LB, 32'h0000_1003, 32'h80FF_7F01, '0));
        checks++;
        if (RuDataWrite !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_off3 got %h exp ffffff80", RuDataWrite);
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd11, 2'b01, F3_LBU, 32'h0000_1003, 32'h80FF_7F01, '0));
        checks++;
        if (RuDataWrite !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu_off3 got %h exp 00000080", RuDataWrite);
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd12, 2'b01, F3_LH, 32'h0000_1002, 32'h80FF_7F01, '0));
        checks++;
        if (RuDataWrite !== 32'hFFFF_80FF) begin
            errors++; $display("FAIL lh_off2 got %h exp ffff80ff", RuDataWrite);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, mk(1'b1, 1'b1, 5'(i + 13), 2'b01, (i % 2 == 0) ? F3_LHU : F3_LBU,
                          32'(i), $urandom, '0));
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd20, 2'b01, F3_LW, 32'h0000_2000, 32'hA5A5_0F0F, '0));
        step(1'b0, mk(1'b1, 1'b1, 5'd21, 2'b01, 3'b111, 32'h0000_2000, 32'h0BAD_F00D, '0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL loads got %h exp %h", o, e); end
        end
    endtask

    task automatic test_x0_misalign();
        out_t        e, o;
        logic [CW-1:0] r0;
        r0 = retired;
        step(1'b0, mk(1'b1, 1'b1, 5'd0, 2'b00, F3_LW, 32'h0000_0042, '0, '0));
        checks++;
        if (Ruwr !== 1'b0 || wb_valid !== 1'b1 || retired !== r0 + CW'(1)) begin
            errors++;
            $display("FAIL x0_write got ruwr=%b v=%b ret=%0d", Ruwr, wb_valid, retired);
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd3, 2'b01, F3_LW, 32'h0000_0102, 32'h1111_2222, '0));
        checks++;
        if (Ruwr !== 1'b0 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL lw_off2 got ruwr=%b mis=%b exp 0/1", Ruwr, misalign_err);
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd4, 2'b01, F3_LH, 32'h0000_0101, 32'h1111_2222, '0));
        checks++;
        if (misalign_err !== 1'b1) begin
            errors++; $display("FAIL lh_off1 got mis=%b exp 1", misalign_err);
        end
        step(1'b0, mk(1'b1, 1'b1, 5'd4, 2'b00, F3_LW, 32'h0000_0101, 32'h1111_2222, '0));
        step(1'b0, mk(1'b1, 1'b1, 5'd6, 2'b01, F3_LB, 32'h0000_0101, 32'h1111_2222, '0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL x0_misalign got %h exp %h", o, e); end
        end
    endtask

    task automatic test_stall_flush();
        out_t          e, o;
        in_t           s;
        logic [CW-1:0] r0;
        step(1'b0, mk(1'b1, 1'b1, 5'd8, 2'b00, F3_LW, 32'h0BEE_F000, '0, '0));
        r0 = retired;
        for (int i = 0; i < 3; i++) begin
            s = mk(1'b1, 1'b1, 5'(i + 1), 2'b00, F3_LW, $urandom, '0, '0);
            s.stall = 1'b1;
            step(1'b0, s);
        end
        checks++;
        if (retired !== r0 || RuDataWrite !== 32'h0BEE_F000 || rd !== 5'd8) begin
            errors++;
            $display("FAIL stall_hold got data=%h rd=%0d ret=%0d", RuDataWrite, rd, retired);
        end
        s = mk(1'b1, 1'b1, 5'd9, 2'b00, F3_LW, 32'h7777_0000, '0, '0);
        s.stall = 1'b1;
        s.flush = 1'b1;
        step(1'b0, s);
        checks++;
        if (Ruwr !== 1'b0 || wb_valid !== 1'b0 || retired !== r0) begin
            errors++;
            $display("FAIL stall_flush got ruwr=%b v=%b ret=%0d", Ruwr, wb_valid, retired);
        end
        step(1'b0, mk(1'b0, 1'b1, 5'd9, 2'b00, F3_LW, 32'h7777_0000, '0, '0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_flush_sb got %h exp %h", o, e); end
        end
    endtask

    task automatic test_pc4();
        out_t e, o;
        step(1'b0, mk(1'b1, 1'b1, 5'd1, 2'b10, F3_LW, 32'h0000_0200, 32'h0, 32'h0000_0104));
        checks++;
        if (RuDataWrite !== 32'h0000_0104 || Ruwr !== 1'b1 || rd !== 5'd1) begin
            errors++;
            $display("FAIL jal_pc4 got data=%h ruwr=%b rd=%0d", RuDataWrite, Ruwr, rd);
        end
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL pc4 got %h exp %h", o, e); end
        end
    endtask

    task automatic test_back_to_back_wrap();
        out_t e, o;
        step(1'b1, mk(1'b0, 1'b0, 5'd0, 2'b00, F3_LW, '0, '0, '0));
        for (int i = 0; i < 17; i++) begin
            step(1'b0, mk(1'b1, 1'b1, 5'(i), 2'(i % 3), F3_LW, 32'(i * 4), $urandom, 32'(i + 4)));
        end
        checks++;
        if (retired !== 4'd1) begin
            errors++; $display("FAIL wrap17 got retired=%0d exp 1", retired);
        end
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap got %h exp %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_stall();
        out_t e, o;
        in_t  s;
        step(1'b0, mk(1'b1, 1'b1, 5'd30, 2'b00, F3_LW, 32'h3030_3030, '0, '0));
        s = mk(1'b1, 1'b1, 5'd31, 2'b00, F3_LW, 32'h3131_3131, '0, '0);
        s.stall = 1'b1;
        step(1'b0, s);
        step(1'b1, s);
        checks++;
        if ({RuDataWrite, rd, Ruwr, wb_valid, misalign_err, retired} !== '0) begin
            errors++;
            $display("FAIL rst_mid_stall got data=%h rd=%0d ret=%0d", RuDataWrite, rd, retired);
        end
        step(1'b0, s);
        step(1'b0, mk(1'b1, 1'b1, 5'd2, 2'b00, F3_LW, 32'h0000_0ABC, '0, '0));
        checks++;
        if (retired !== 4'd1 || RuDataWrite !== 32'h0000_0ABC) begin
            errors++;
            $display("FAIL first_after_rst got data=%h ret=%0d", RuDataWrite, retired);
        end
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_stall_sb got %h exp %h", o, e); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_loads();
        test_x0_misalign();
        test_stall_flush();
        test_pc4();
        test_back_to_back_wrap();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the segmented RV32I core.
- Captures MEM-stage results and selects the write source (ALU, load data, PC+4).
- Aligns and sign/zero-extends loads.
- Drives the register file write port (RuDataWrite/rd/Ruwr). The register file commits on negedge, so all three outputs are flop outputs and stay stable for the full cycle.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  replace the captured instruction with a bubble.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_ruwr  in  1  instruction writes a register.
- mem_rd  in  5  destination register.
- mem_wb_src  in  2  write source: 00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU).
- mem_dm_ctrl  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes behave as lw.
- mem_alu_res  in  XLEN  ALU result; also the load byte address.
- mem_rd_word  in  XLEN  raw aligned word read from data memory.
- mem_pc4  in  XLEN  PC+4 of the instruction.
- RuDataWrite  out  XLEN  register file write data.
- rd  out  5  register file write address.
- Ruwr  out  1  register file write enable.
- wb_valid  out  1  WB holds a real instruction this cycle.
- misalign_err  out  1  the held load was misaligned; its write is suppressed.
- retired  out  CNT_W  count of instructions captured into WB.

Behaviour:
- Reset (posedge with rst=1): RuDataWrite=0, rd=0, Ruwr=0, wb_valid=0, misalign_err=0, retired=0. rst has priority over flush and stall.
- Priority when rst=0: flush > stall > capture.
- flush=1: wb_valid=0, Ruwr=0, misalign_err=0. rd and RuDataWrite are cleared to 0. retired is unchanged.
- stall=1 (no flush): all outputs hold, and retired does not increment, so a held instruction is never counted twice.
- Capture: latency is 1 cycle. Inputs at posedge N appear at the outputs after posedge N and are committed by the register file at the following negedge.
- Data selection (combinational, before the flops):
  - ALU source: mem_alu_res.
  - PC+4 source: mem_pc4.
  - Load source: shifted by off = mem_alu_res[1:0].
    - lb/lbu: byte = word[8*off +: 8]; sign- or zero-extend to XLEN.
    - lh/lhu: half = word[16*off[1] +: 16]; sign- or zero-extend.
    - lw: the whole word.
- Misalignment applies only when mem_wb_src=01:
  - lh/lhu with off[0]=1 is misaligned.
  - lw with off!=0 is misaligned.
  - lb/lbu are never misaligned.
- Captured misalign_err = mem_valid & (wb_src==01) & misaligned. It is a one-instruction flag, not sticky.
- Captured Ruwr = mem_valid & mem_ruwr & (mem_rd!=0) & ~misaligned.
  - x0 is never written, even when mem_ruwr=1.
- rd and RuDataWrite are captured whenever mem_valid=1, even if Ruwr=0. When mem_valid=0 they are captured as 0.
- retired increments by 1 on each capture with mem_valid=1, including misaligned loads and writes to x0. It wraps at 2^CNT_W.
- mem_valid=0 with no stall or flush captures a bubble: wb_valid=0, Ruwr=0.
- Reset asserted mid-stall clears all state in that cycle. After rst drops, the first capture occurs on the next non-stalled posedge.

Decomposition:
- Shared package riscv_pkg:
  - enum wb_src_e (WB_ALU, WB_MEM, WB_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN default.
- Sub-module load_extract: purely combinational. Inputs word, off, funct3; outputs extended data and misaligned. It is reused later by the store/MMIO path.

Test Plan:
- Reset, then ALU write: mem_wb_src=00, mem_rd=5, mem_alu_res=0x1234_5678, mem_valid=1, mem_ruwr=1. Next cycle: Ruwr=1, rd=5, RuDataWrite=0x1234_5678, retired=1.
- Signed byte load: lb, word=0x80FF_7F01, off=3 gives 0xFFFF_FF80. lbu with off=3 gives 0x0000_0080. lh with off=2 gives 0xFFFF_80FF.
- x0 and misalignment:
  - mem_rd=0 with mem_ruwr=1 gives Ruwr=0, wb_valid=1, retired+1.
  - lw with off=2 gives Ruwr=0, misalign_err=1.
  - lh with off=1 gives misalign_err=1.
- Stall/flush priority: stall for 3 cycles gives outputs held and retired constant. stall=1 with flush=1 gives a bubble (Ruwr=0, wb_valid=0).
- PC+4 source (jal): mem_wb_src=10, mem_pc4=0x0000_0104, rd=1. Result: RuDataWrite=0x104, Ruwr=1.
- Counter wrap and reset: with CNT_W=4, 17 valid captures give retired=1. Asserting rst mid-stall zeroes every output on the next posedge.
